// File: rtl/encrypted_msg_loader.sv
// encrypted_msg_loader: reads MSG_LEN message bytes from a synchronous ROM,
// one address per cycle. A tag pipeline matched to the ROM read latency
// steers each returning byte into its slot. Once the last byte has been
// captured, read_rom_done is raised so the decryption cores can start.
// Optional feature macro: ROM_CHECKSUM_EN adds msg_checksum, the running XOR
// of every byte captured in the current load.
module encrypted_msg_loader #(
  parameter int MSG_LEN     = 32,
  parameter int ADDR_W      = 5,
  parameter int ROM_LATENCY = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] rom_address,
  output logic [7:0]        rom_data_d [MSG_LEN-1:0],
  output logic              read_rom_done,
  output logic              busy
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [7:0]        msg_checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_END  = (ADDR_W+1)'(MSG_LEN);
  localparam logic [ADDR_W-1:0] LAST_TAG = ADDR_W'(MSG_LEN-1);

  state_t state, next_state;

  logic [ADDR_W:0]         issue_cnt;
  logic                    addr_valid;
  logic [ROM_LATENCY-1:0]  pipe_valid;
  logic [ADDR_W-1:0]       pipe_tag [ROM_LATENCY];
  logic                    load_start;
  logic                    issue_step;
  logic                    issue_end;
  logic                    capture;
  logic [ADDR_W-1:0]       capture_tag;

  assign capture     = pipe_valid[ROM_LATENCY-1];
  assign capture_tag = pipe_tag[ROM_LATENCY-1];

  assign read_rom_done = (state == DONE);
  assign busy          = (state == ISSUE) || (state == DRAIN);

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    next_state = state;
    load_start = 1'b0;
    issue_step = 1'b0;
    issue_end  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load_start = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt == CNT_END) begin
          issue_end  = 1'b1;
          next_state = DRAIN;
        end else begin
          issue_step = 1'b1;
        end
      end
      DRAIN: begin
        if (capture && (capture_tag == LAST_TAG)) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address issue: present 0 at the start edge, then one new address per cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rom_address <= '0;
      issue_cnt   <= '0;
      addr_valid  <= 1'b0;
    end else if (load_start) begin
      rom_address <= '0;
      issue_cnt   <= (ADDR_W+1)'(1);
      addr_valid  <= 1'b1;
    end else if (issue_step) begin
      rom_address <= issue_cnt[ADDR_W-1:0];
      issue_cnt   <= issue_cnt + 1'b1;
    end else if (issue_end) begin
      addr_valid  <= 1'b0;
    end
  end

  // Tag pipeline that tracks each presented address through the ROM latency
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_tag[i]   <= '0;
      end
    end else begin
      pipe_valid[0] <= addr_valid;
      pipe_tag[0]   <= rom_address;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // Byte capture into the tagged slot; all slots are wiped when a load starts
  always_ff @(posedge CLOCK_50) begin
    if (reset || load_start) begin
      for (int k = 0; k < MSG_LEN; k++) rom_data_d[k] <= 8'h00;
    end else if (capture) begin
      for (int k = 0; k < MSG_LEN; k++) begin
        if (capture_tag == ADDR_W'(k)) rom_data_d[k] <= rom_q;
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  // Running XOR of the bytes captured since the last start
  always_ff @(posedge CLOCK_50) begin
    if (reset || load_start) msg_checksum <= 8'h00;
    else if (capture)        msg_checksum <= msg_checksum ^ rom_q;
  end
`endif

endmodule
